// File: rtl/idu_issue_queue.sv
// idu_issue_queue: RV64 decode stage with an IQ_DEPTH-entry queue, load-use scoreboard and registered output; define IDU_RVM_EN for M decode.
// Latency: enqueue to out_* in one cycle minimum. Backpressure: in_ready = !full & !flush; out_* hold while out_valid & !out_ready.
module idu_issue_queue #(
    parameter int XLEN     = 64,
    parameter int PC_W     = 64,
    parameter int IQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic [2:0]      out_mem_size,
    output logic            out_illegal,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic            ld_done_valid,
    input  logic [4:0]      ld_done_rd
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_ADDW = 5'd10;
    localparam logic [4:0] OP_SUBW = 5'd11;
    localparam logic [4:0] OP_SLLW = 5'd12;
    localparam logic [4:0] OP_SRLW = 5'd13;
    localparam logic [4:0] OP_SRAW = 5'd14;
`ifdef IDU_RVM_EN
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_MULW = 5'd24;
    localparam logic [4:0] OP_DIVW = 5'd25;
`endif
    localparam logic [4:0] OP_CSR  = 5'd29;
    localparam logic [4:0] OP_SYS  = 5'd30;

    logic [31:0]     iq_inst_q [IQ_DEPTH];
    logic [PC_W-1:0] iq_pc_q   [IQ_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]     sb_q, sb_d;
    logic            out_valid_q, out_valid_d;

    logic [PC_W-1:0] out_pc_q;
    logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q, out_alu_op_q;
    logic            out_rd_wen_q, out_is_load_q, out_is_store_q, out_illegal_q;
    logic [XLEN-1:0] out_imm_q;
    logic [2:0]      out_mem_size_q;

    logic full, empty, enq, issue, out_fire, hazard;
    logic [31:0] h_inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;

    logic            use_rs1, use_rs2, use_rd, d_ill, d_ld, d_st;
    logic [4:0]      d_op, d_rs1, d_rs2, d_rd, r_op;
    logic [XLEN-1:0] d_imm, r_imm;
    logic [2:0]      d_size;
    logic            d_wen;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign in_ready = !full && !flush;
    assign enq      = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready && !flush;

    assign h_inst = iq_inst_q[rd_ptr_q[AW-1:0]];
    assign opc    = h_inst[6:0];
    assign f3     = h_inst[14:12];
    assign f7     = h_inst[31:25];

    assign imm_i = {{(XLEN-12){h_inst[31]}}, h_inst[31:20]};
    assign imm_s = {{(XLEN-12){h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
    assign imm_b = {{(XLEN-13){h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){h_inst[31]}}, h_inst[31:12], 12'h000};
    assign imm_j = {{(XLEN-21){h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        d_imm   = '0;
        d_op    = OP_ADD;
        d_ld    = 1'b0;
        d_st    = 1'b0;
        d_size  = 3'd0;
        d_ill   = 1'b0;
        case (opc)
            7'b0110111, 7'b0010111: begin use_rd = 1'b1; d_imm = imm_u; end
            7'b1101111: begin use_rd = 1'b1; d_imm = imm_j; end
            7'b1100111: begin use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i; d_ill = (f3 != 3'd0); end
            7'b1100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_b;
                case (f3)
                    3'b000, 3'b001: d_op = OP_SUB;
                    3'b100, 3'b101: d_op = OP_SLT;
                    3'b110, 3'b111: d_op = OP_SLTU;
                    default:        d_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i; d_ld = 1'b1;
                d_size = {1'b0, f3[1:0]}; d_ill = (f3 == 3'b111);
            end
            7'b0100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = imm_s; d_st = 1'b1;
                d_size = {1'b0, f3[1:0]}; d_ill = f3[2];
            end
            7'b0010011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
                case (f3)
                    3'b000: d_op = OP_ADD;
                    3'b010: d_op = OP_SLT;
                    3'b011: d_op = OP_SLTU;
                    3'b100: d_op = OP_XOR;
                    3'b110: d_op = OP_OR;
                    3'b111: d_op = OP_AND;
                    3'b001: begin d_op = OP_SLL; d_ill = (f7[6:1] != 6'd0); end
                    default: begin d_op = f7[5] ? OP_SRA : OP_SRL; d_ill = ({f7[6], f7[4:1]} != 5'd0); end
                endcase
            end
            7'b0011011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = imm_i;
                case (f3)
                    3'b000:  d_op = OP_ADDW;
                    3'b001:  begin d_op = OP_SLLW; d_ill = (f7 != 7'd0); end
                    3'b101:  begin d_op = f7[5] ? OP_SRAW : OP_SRLW; d_ill = ({f7[6], f7[4:0]} != 6'd0); end
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0110011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: d_op = OP_ADD;
                        3'b001: d_op = OP_SLL;
                        3'b010: d_op = OP_SLT;
                        3'b011: d_op = OP_SLTU;
                        3'b100: d_op = OP_XOR;
                        3'b101: d_op = OP_SRL;
                        3'b110: d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_op = OP_SRA;
`ifdef IDU_RVM_EN
                end else if (f7 == 7'b0000001) begin
                    d_op = OP_MUL + {2'b00, f3};
`endif
                end else begin
                    d_ill = 1'b1;
                end
            end
            7'b0111011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (f7 == 7'b0000000 && f3 == 3'b000)      d_op = OP_ADDW;
                else if (f7 == 7'b0000000 && f3 == 3'b001) d_op = OP_SLLW;
                else if (f7 == 7'b0000000 && f3 == 3'b101) d_op = OP_SRLW;
                else if (f7 == 7'b0100000 && f3 == 3'b000) d_op = OP_SUBW;
                else if (f7 == 7'b0100000 && f3 == 3'b101) d_op = OP_SRAW;
`ifdef IDU_RVM_EN
                else if (f7 == 7'b0000001 && f3 == 3'b000) d_op = OP_MULW;
                else if (f7 == 7'b0000001 && f3[2])        d_op = OP_DIVW + {3'b000, f3[1:0]};
`endif
                else d_ill = 1'b1;
            end
            7'b0001111: d_ill = (f3 != 3'd0);
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    d_op  = OP_SYS;
                    d_ill = !(h_inst == 32'h0000_0073 || h_inst == 32'h0010_0073 || h_inst == 32'h3020_0073);
                end else if (f3 == 3'b100) begin
                    d_ill = 1'b1;
                end else begin
                    // Immediate CSR forms carry a uimm in the rs1 field, not a register.
                    d_op = OP_CSR; use_rd = 1'b1; use_rs1 = !f3[2]; d_imm = imm_i;
                end
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign d_rs1 = (use_rs1 && !d_ill) ? h_inst[19:15] : 5'd0;
    assign d_rs2 = (use_rs2 && !d_ill) ? h_inst[24:20] : 5'd0;
    assign d_rd  = (use_rd  && !d_ill) ? h_inst[11:7]  : 5'd0;
    assign d_wen = (d_rd != 5'd0);
    assign r_op  = d_ill ? OP_ADD : d_op;
    assign r_imm = d_ill ? '0 : d_imm;

    assign hazard = ((d_rs1 != 5'd0) && (sb_q[d_rs1] || (out_valid_q && out_is_load_q && d_rs1 == out_rd_q))) ||
                    ((d_rs2 != 5'd0) && (sb_q[d_rs2] || (out_valid_q && out_is_load_q && d_rs2 == out_rd_q)));
    assign issue  = !empty && !hazard && (!out_valid_q || out_fire) && !flush;

    assign rf_rs1 = empty ? 5'd0 : d_rs1;
    assign rf_rs2 = empty ? 5'd0 : d_rs2;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq)   wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        out_valid_d = out_valid_q;
        if (flush)         out_valid_d = 1'b0;
        else if (issue)    out_valid_d = 1'b1;
        else if (out_fire) out_valid_d = 1'b0;
        // Set after clear so a load refiring to the same rd keeps its bit.
        sb_d = sb_q;
        if (ld_done_valid) sb_d[ld_done_rd] = 1'b0;
        if (out_fire && out_is_load_q && out_rd_q != 5'd0) sb_d[out_rd_q] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            iq_inst_q[wr_ptr_q[AW-1:0]] <= in_inst;
            iq_pc_q[wr_ptr_q[AW-1:0]]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sb_q           <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_rs1_q      <= 5'd0;
            out_rs2_q      <= 5'd0;
            out_rd_q       <= 5'd0;
            out_rd_wen_q   <= 1'b0;
            out_imm_q      <= '0;
            out_alu_op_q   <= 5'd0;
            out_is_load_q  <= 1'b0;
            out_is_store_q <= 1'b0;
            out_mem_size_q <= 3'd0;
            out_illegal_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            if (issue) begin
                out_pc_q       <= iq_pc_q[rd_ptr_q[AW-1:0]];
                out_rs1_q      <= d_rs1;
                out_rs2_q      <= d_rs2;
                out_rd_q       <= d_rd;
                out_rd_wen_q   <= d_wen;
                out_imm_q      <= r_imm;
                out_alu_op_q   <= r_op;
                out_is_load_q  <= d_ld && !d_ill;
                out_is_store_q <= d_st && !d_ill;
                out_mem_size_q <= d_size;
                out_illegal_q  <= d_ill;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1      = out_rs1_q;
    assign out_rs2      = out_rs2_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_imm      = out_imm_q;
    assign out_alu_op   = out_alu_op_q;
    assign out_is_load  = out_is_load_q;
    assign out_is_store = out_is_store_q;
    assign out_mem_size = out_mem_size_q;
    assign out_illegal  = out_illegal_q;
endmodule

// File: tb/tb_idu_issue_queue.sv
// Directed bench for idu_issue_queue: latency, fill/backpressure, load-use stalls, flush, decode and wrap streaming.
module tb_idu_issue_queue;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op, rf_rs1, rf_rs2, ld_done_rd;
    logic        out_rd_wen, out_is_load, out_is_store, out_illegal, ld_done_valid;
    logic [2:0]  out_mem_size;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] ADDI5 = 32'h0050_0093;
    localparam logic [31:0] LD5   = 32'h0001_3283;
    localparam logic [31:0] ADD6  = 32'h0012_8333;
    localparam logic [31:0] LD7   = 32'h0001_3383;
    localparam logic [31:0] ADD8  = 32'h0003_8433;

    idu_issue_queue #(.XLEN(64), .PC_W(64), .IQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_mem_size(out_mem_size), .out_illegal(out_illegal), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves one instruction held in the output register (out_ready low).
    task automatic issue_one(input logic [31:0] inst, input logic [63:0] pc);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        step();
        in_valid = 1'b0;
        step();
        chk("issue_one_vld", out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic load_use(input bit same_cycle);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = LD5; in_pc = 64'h2000;
        step();
        in_inst = ADD6; in_pc = 64'h2004;
        step();
        in_valid = 1'b0;
        chk("lu_ld_vld", out_valid, 1);
        chk("lu_ld_isld", out_is_load, 1);
        chk("lu_ld_rd", out_rd, 5);
        chk("lu_ld_size", out_mem_size, 3);
        if (same_cycle) begin ld_done_valid = 1'b1; ld_done_rd = 5'd5; end
        step();
        ld_done_valid = 1'b0;
        chk("lu_stall0", out_valid, 0);
        step();
        chk("lu_stall1", out_valid, 0);
        step();
        chk("lu_stall2", out_valid, 0);
        ld_done_valid = 1'b1; ld_done_rd = 5'd5;
        step();
        ld_done_valid = 1'b0;
        chk("lu_stall3", out_valid, 0);
        step();
        chk("lu_add_vld", out_valid, 1);
        chk("lu_add_rd", out_rd, 6);
        chk("lu_add_rs1", out_rs1, 5);
        chk("lu_add_rs2", out_rs2, 1);
        step();
        chk("lu_add_gone", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int idx, tx, rx, gaps;
        bit started, acc;
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
        out_ready = 1'b0; ld_done_valid = 1'b0; ld_done_rd = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_rf_rs1", rf_rs1, 0);

        // addi x1,x0,5: visible two edges after the handshake cycle
        in_valid = 1'b1; in_inst = ADDI5; in_pc = 64'h8000_0000;
        step();
        in_valid = 1'b0;
        chk("lat_not_yet", out_valid, 0);
        step();
        chk("lat_vld", out_valid, 1);
        chk("addi_rd", out_rd, 1);
        chk("addi_wen", out_rd_wen, 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_op", out_alu_op, 0);
        chk("addi_ill", out_illegal, 0);
        chk("addi_pc", out_pc, 64'h8000_0000);
        step();
        chk("addi_hold_pc", out_pc, 64'h8000_0000);
        drain();
        chk("addi_drained", out_valid, 0);

        // Fill: 4 in queue + 1 in the output register, then backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst = (i << 20) | ((i + 1) << 7) | 32'h13;
            in_pc = 64'h1000 + 4 * i;
            chk("fill_rdy", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        chk("fill_full", in_ready, 0);
        chk("fill_out_pc", out_pc, 64'h1000);
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (out_valid) begin
                chk("fill_order_pc", out_pc, 64'h1000 + 4 * idx);
                chk("fill_order_rd", out_rd, idx + 1);
                idx++;
            end
            step();
        end
        chk("fill_count", idx, 5);
        chk("fill_empty", out_valid, 0);

        load_use(1'b0);
        load_use(1'b1);

        // Flush with 3 queued and the output register full; x7 scoreboard bit must survive
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = LD7; in_pc = 64'h3000;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("fl_ld_fired", out_valid, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst = (i << 20) | ((10 + i) << 7) | 32'h13;
            in_pc = 64'h3100 + 4 * i;
            step();
        end
        in_valid = 1'b0;
        chk("fl_pre_vld", out_valid, 1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready_low", in_ready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("fl_queue_empty", out_valid, 0);
        in_valid = 1'b1; in_inst = ADD8; in_pc = 64'h3200;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("fl_sb_kept", out_valid, 0);
        ld_done_valid = 1'b1; ld_done_rd = 5'd7;
        step();
        ld_done_valid = 1'b0;
        step();
        chk("fl_add_vld", out_valid, 1);
        chk("fl_add_rd", out_rd, 8);
        chk("fl_add_pc", out_pc, 64'h3200);
        drain();

        // Decode patterns
        issue_one(32'hFFF0_0093, 64'h5000);
        chk("neg_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        issue_one(32'h1234_5537, 64'h5004);
        chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
        chk("lui_rd", out_rd, 10);
        drain();
        issue_one(32'h4020_8233, 64'h5008);
        chk("sub_op", out_alu_op, 1);
        chk("sub_rs1", out_rs1, 1);
        chk("sub_rs2", out_rs2, 2);
        chk("sub_imm", out_imm, 0);
        drain();
        issue_one(32'h0020_A423, 64'h500C);
        chk("sw_store", out_is_store, 1);
        chk("sw_size", out_mem_size, 2);
        chk("sw_imm", out_imm, 8);
        chk("sw_wen", out_rd_wen, 0);
        chk("sw_rd", out_rd, 0);
        drain();
        issue_one(32'hFFFF_FFFF, 64'h5010);
        chk("ill_flag", out_illegal, 1);
        chk("ill_wen", out_rd_wen, 0);
        chk("ill_rd", out_rd, 0);
        chk("ill_rs1", out_rs1, 0);
        drain();
        issue_one(32'h0010_0013, 64'h5014);
        chk("x0_wen", out_rd_wen, 0);
        drain();
        issue_one(32'h0220_81B3, 64'h5018);
`ifdef IDU_RVM_EN
        chk("mul_op", out_alu_op, 16);
        chk("mul_ill", out_illegal, 0);
        chk("mul_wen", out_rd_wen, 1);
`else
        chk("mul_ill", out_illegal, 1);
        chk("mul_wen", out_rd_wen, 0);
        chk("mul_rd", out_rd, 0);
`endif
        drain();

        // Streaming at full occupancy across many pointer wraps
        tx = 0; rx = 0; gaps = 0; started = 1'b0;
        for (int cyc = 0; cyc < 400 && rx < 60; cyc++) begin
            out_ready = (cyc >= 8);
            if (out_valid && out_ready) begin
                chk("stream_pc", out_pc, 64'h4000 + 4 * rx);
                chk("stream_imm", out_imm, rx);
                rx++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            in_valid = (tx < 60);
            in_inst = {tx[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
            in_pc = 64'h4000 + 4 * tx;
            acc = in_valid && in_ready;
            step();
            if (acc) tx++;
        end
        in_valid = 1'b0;
        chk("stream_tx", tx, 60);
        chk("stream_rx", rx, 60);
        chk("stream_gaps", gaps, 0);

        // Reset mid-operation also clears the scoreboard
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = LD5; in_pc = 64'h6000;
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = ADDI5; in_pc = 64'h6004;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_pc", out_pc, 0);
        chk("mrst_rf_rs1", rf_rs1, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = ADD6; in_pc = 64'h6100;
        step();
        in_valid = 1'b0;
        step();
        chk("mrst_add_vld", out_valid, 1);
        chk("mrst_add_pc", out_pc, 64'h6100);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
